// File: rtl/hash_job_scheduler_if.sv
// Bundle between the nonce-search job scheduler and its environment:
// the job control, the per-unit dispatch/report lanes and the result FIFO read port.
interface hash_job_scheduler_if #(
    parameter int NUM_UNITS = 4,
    parameter int NONCE_W   = 32
);
    // Job control and status
    logic                         start;
    logic                         stop;
    logic [NONCE_W-1:0]           nonce_start;
    logic [NONCE_W-1:0]           nonce_end;
    logic [15:0]                  chunk_size;
    logic                         busy;
    logic                         done;
    logic                         irq;

    // Dispatch lanes
    logic [NUM_UNITS-1:0]         unit_ready;
    logic [NUM_UNITS-1:0]         unit_load;
    logic [NONCE_W-1:0]           unit_nonce_base;
    logic [16:0]                  unit_nonce_count;

    // Solution report lanes
    logic [NUM_UNITS-1:0]         unit_found;
    logic [NUM_UNITS*NONCE_W-1:0] unit_found_nonce;
    logic [NUM_UNITS-1:0]         unit_found_ack;

    // Result FIFO read port
    logic                         res_valid;
    logic [NONCE_W-1:0]           res_nonce;
    logic [2:0]                   res_unit;
    logic                         res_pop;

    // Environment side: host control, hash units and the SPI reader
    modport master (
        output start, stop, nonce_start, nonce_end, chunk_size,
        output unit_ready, unit_found, unit_found_nonce, res_pop,
        input  busy, done, irq, unit_load, unit_nonce_base, unit_nonce_count,
        input  unit_found_ack, res_valid, res_nonce, res_unit
    );

    // Scheduler side
    modport slave (
        input  start, stop, nonce_start, nonce_end, chunk_size,
        input  unit_ready, unit_found, unit_found_nonce, res_pop,
        output busy, done, irq, unit_load, unit_nonce_base, unit_nonce_count,
        output unit_found_ack, res_valid, res_nonce, res_unit
    );
endinterface

// File: rtl/hash_job_scheduler.sv
// Nonce-search job scheduler on the M1 hash clock. Splits an inclusive nonce
// range into chunks handed round-robin to ready hash units, and collects
// solution reports round-robin into a small first-word-fall-through FIFO.
module hash_job_scheduler #(
    parameter int NUM_UNITS  = 4,
    parameter int NONCE_W    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic                 M1_CLK,
    input logic                 hash_clock_reset,
    hash_job_scheduler_if.slave bus
);
    localparam int PW  = $clog2(NUM_UNITS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int NW1 = NONCE_W + 1;
    localparam int RW  = (NW1 > 17) ? NW1 : 17;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_e;

    typedef struct packed {
        logic          hit;
        logic [PW-1:0] idx;
    } pick_t;

    typedef struct packed {
        logic [NONCE_W-1:0] nonce;
        logic [PW-1:0]      unit;
    } result_t;

    // First requester at or after ptr, circularly. Scanning from the far end
    // lets the nearest requester overwrite earlier candidates.
    function automatic pick_t rr_pick(input logic [NUM_UNITS-1:0] req,
                                      input logic [PW-1:0]        ptr);
        pick_t p;
        int    j;
        p = '0;
        for (int k = NUM_UNITS - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_UNITS) j = j - NUM_UNITS;
            if (req[PW'(j)]) begin
                p.hit = 1'b1;
                p.idx = PW'(j);
            end
        end
        return p;
    endfunction

    function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] idx);
        return (int'(idx) == NUM_UNITS - 1) ? '0 : idx + 1'b1;
    endfunction

    state_e             state_q;
    logic [NONCE_W-1:0] next_nonce_q, next_nonce_d;
    logic [NONCE_W-1:0] end_q;
    logic [15:0]        chunk_q;
    logic [PW-1:0]      rr_disp_q, rr_disp_d;

    pick_t              disp_pick;
    logic [16:0]        chunk_eff;
    logic [RW-1:0]      remaining;
    logic [16:0]        disp_count;
    logic               disp_last;
    logic               disp_fire;

    result_t            mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [AW:0]        cnt_q;
    logic [PW-1:0]      rr_found_q;

    pick_t              found_pick;
    logic [NONCE_W-1:0] found_nonce;
    logic               fifo_full;
    logic               push;
    logic               pop;

    // Chunk sizing and dispatch grant for the current cycle
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch can be inferred.
        disp_pick    = rr_pick(bus.unit_ready, rr_disp_q);
        chunk_eff    = (chunk_q == '0) ? 17'd1 : {1'b0, chunk_q};
        // One bit wider than a nonce so a full 2^NONCE_W range does not wrap to zero
        remaining    = RW'({1'b0, end_q} - {1'b0, next_nonce_q} + NW1'(1));
        disp_last    = (remaining <= RW'(chunk_eff));
        disp_count   = disp_last ? remaining[16:0] : chunk_eff;
        disp_fire    = (state_q == S_DISPATCH) && !bus.stop && disp_pick.hit;
        next_nonce_d = next_nonce_q + NONCE_W'(disp_count);
        rr_disp_d    = rr_next(disp_pick.idx);
    end

    // Job sequencing: IDLE -> DISPATCH -> DRAIN -> DONE, stop aborts from anywhere
    always_ff @(posedge M1_CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (hash_clock_reset) begin
            state_q      <= S_IDLE;
            next_nonce_q <= '0;
            end_q        <= '0;
            chunk_q      <= '0;
            rr_disp_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A simultaneous stop is ignored here: start wins
                    if (bus.start) begin
                        next_nonce_q <= bus.nonce_start;
                        end_q        <= bus.nonce_end;
                        chunk_q      <= bus.chunk_size;
                        state_q      <= (bus.nonce_start > bus.nonce_end) ? S_DONE : S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (bus.stop) begin
                        state_q <= S_IDLE;
                    end else if (disp_fire) begin
                        next_nonce_q <= next_nonce_d;
                        rr_disp_q    <= rr_disp_d;
                        if (disp_last) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.stop) begin
                        state_q <= S_IDLE;
                    end else if ((&bus.unit_ready) && !(|bus.unit_found)) begin
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Report arbitration: one winner per cycle while the FIFO has room
    always_comb begin
        found_pick  = rr_pick(bus.unit_found, rr_found_q);
        found_nonce = bus.unit_found_nonce[found_pick.idx * NONCE_W +: NONCE_W];
        fifo_full   = (cnt_q == (AW + 1)'(FIFO_DEPTH));
        push        = found_pick.hit && !fifo_full;
        pop         = bus.res_pop && (cnt_q != '0);
    end

    // FIFO pointers, occupancy and report round-robin pointer
    always_ff @(posedge M1_CLK) begin
        if (hash_clock_reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            rr_found_q <= '0;
        end else begin
            if (push) begin
                wr_q       <= wr_q + 1'b1;
                rr_found_q <= rr_next(found_pick.idx);
            end
            if (pop) rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // FIFO storage write
    always_ff @(posedge M1_CLK) begin
        // NOTE: storage is not reset; a flush is done by the pointers and the head is masked while empty.
        if (push) mem[wr_q] <= '{nonce: found_nonce, unit: found_pick.idx};
    end

    // Output decode; idle lanes and an empty FIFO drive zeros
    always_comb begin
        bus.unit_load        = '0;
        bus.unit_nonce_base  = '0;
        bus.unit_nonce_count = '0;
        bus.unit_found_ack   = '0;
        bus.res_nonce        = '0;
        bus.res_unit         = '0;
        if (disp_fire) begin
            bus.unit_load        = NUM_UNITS'(1) << disp_pick.idx;
            bus.unit_nonce_base  = next_nonce_q;
            bus.unit_nonce_count = disp_count;
        end
        if (push) bus.unit_found_ack = NUM_UNITS'(1) << found_pick.idx;
        bus.res_valid = (cnt_q != '0);
        if (bus.res_valid) begin
            bus.res_nonce = mem[rd_q].nonce;
            bus.res_unit  = 3'(mem[rd_q].unit);
        end
        bus.irq  = bus.res_valid;
        bus.busy = (state_q != S_IDLE);
        bus.done = (state_q == S_DONE);
    end
endmodule

// File: tb/tb_hash_job_scheduler.sv
// Directed bench for hash_job_scheduler: dispatch sequencing, range boundaries,
// report arbitration, FIFO backpressure, stop/restart and reset mid-job.
module tb_hash_job_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    hash_job_scheduler_if #(.NUM_UNITS(4), .NONCE_W(32)) bus ();

    hash_job_scheduler #(.NUM_UNITS(4), .NONCE_W(32), .FIFO_DEPTH(4)) dut (
        .M1_CLK           (clk),
        .hash_clock_reset (rst),
        .bus              (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_load(input string tag, input logic [3:0] load,
                            input logic [31:0] base, input logic [16:0] cnt);
        check({tag, " load"},  bus.unit_load,        load);
        check({tag, " base"},  bus.unit_nonce_base,  base);
        check({tag, " count"}, bus.unit_nonce_count, cnt);
    endtask

    // Inputs change 1 unit after the rising edge, outputs are sampled 1 unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [31:0] exp_nonce [4];
    logic [2:0]  exp_unit  [4];

    initial begin
        bus.start = 0; bus.stop = 0; bus.nonce_start = 0; bus.nonce_end = 0;
        bus.chunk_size = 0; bus.unit_ready = 0; bus.unit_found = 0;
        bus.unit_found_nonce = 0; bus.res_pop = 0;
        rst = 1;
        step(); step(); settle();
        check("rst busy",  bus.busy, 0);
        check("rst valid", bus.res_valid, 0);
        check("rst irq",   bus.irq, 0);
        check("rst done",  bus.done, 0);
        check("rst ack",   bus.unit_found_ack, 0);
        check("rst nonce", bus.res_nonce, 0);
        check("rst unit",  bus.res_unit, 0);
        chk_load("rst", 4'b0000, 0, 0);

        // Range 0x100..0x1FF, chunk 64, four units ready
        step(); rst = 0; bus.unit_ready = 4'hF; bus.start = 1;
        bus.nonce_start = 32'h100; bus.nonce_end = 32'h1FF; bus.chunk_size = 16'd64; settle();
        check("t1 start busy", bus.busy, 0);
        check("t1 start load", bus.unit_load, 0);
        for (int i = 0; i < 4; i++) begin
            step(); bus.start = 0; bus.unit_ready = 4'hF << i; settle();
            chk_load($sformatf("t1 chunk%0d", i), 4'b0001 << i, 32'h100 + 32'(64 * i), 17'd64);
            check("t1 busy", bus.busy, 1);
        end
        step(); bus.unit_ready = 4'h0; settle();
        check("t1 drain load", bus.unit_load, 0);
        check("t1 drain busy", bus.busy, 1);
        check("t1 drain done", bus.done, 0);
        step(); bus.unit_ready = 4'hF; settle();
        check("t1 ready done", bus.done, 0);
        step(); settle();
        check("t1 done", bus.done, 1);
        step(); settle();
        check("t1 done end", bus.done, 0);
        check("t1 idle", bus.busy, 0);

        // Top of nonce space, one unit ready
        step(); bus.unit_ready = 4'b0100; bus.start = 1;
        bus.nonce_start = 32'hFFFF_FFF0; bus.nonce_end = 32'hFFFF_FFFF; bus.chunk_size = 16'h100; settle();
        step(); bus.start = 0; settle();
        chk_load("t2", 4'b0100, 32'hFFFF_FFF0, 17'd16);
        step(); bus.unit_ready = 4'h0; settle();
        check("t2 single load", bus.unit_load, 0);
        check("t2 drain busy", bus.busy, 1);
        step(); bus.unit_ready = 4'hF; settle();
        check("t2 ready done", bus.done, 0);
        step(); settle();
        check("t2 done", bus.done, 1);
        step(); settle();
        check("t2 idle", bus.busy, 0);

        // Units 1 and 3 report together
        step(); bus.unit_found = 4'b1010;
        bus.unit_found_nonce = {32'h3333, 32'h0, 32'h1111, 32'h0}; settle();
        check("t3 ack u1", bus.unit_found_ack, 4'b0010);
        check("t3 valid lat", bus.res_valid, 0);
        step(); bus.unit_found = 4'b1000; settle();
        check("t3 ack u3", bus.unit_found_ack, 4'b1000);
        check("t3 valid", bus.res_valid, 1);
        check("t3 irq", bus.irq, 1);
        check("t3 head nonce", bus.res_nonce, 32'h1111);
        check("t3 head unit", bus.res_unit, 1);
        step(); bus.unit_found = 4'b0000; bus.res_pop = 1; settle();
        check("t3 no ack", bus.unit_found_ack, 0);
        check("t3 head1 nonce", bus.res_nonce, 32'h1111);
        step(); settle();
        check("t3 head2 nonce", bus.res_nonce, 32'h3333);
        check("t3 head2 unit", bus.res_unit, 3);
        step(); settle();
        check("t3 empty", bus.res_valid, 0);
        check("t3 irq low", bus.irq, 0);
        step(); bus.res_pop = 0; settle();
        check("t3 empty pop", bus.res_valid, 0);

        // Fill the FIFO, then unit 2 must wait for a pop
        for (int i = 0; i < 4; i++) begin
            step(); bus.unit_found = 4'b0001; bus.unit_found_nonce = 128'(32'hA0 + 32'(i)); settle();
            check($sformatf("t4 fill%0d ack", i), bus.unit_found_ack, 4'b0001);
        end
        step(); bus.unit_found = 4'b0100; bus.unit_found_nonce = {32'h0, 32'hC2, 32'h0, 32'h0}; settle();
        check("t4 full no ack", bus.unit_found_ack, 0);
        check("t4 full head", bus.res_nonce, 32'hA0);
        step(); bus.res_pop = 1; settle();
        check("t4 pop full no ack", bus.unit_found_ack, 0);
        step(); bus.res_pop = 0; settle();
        check("t4 ack after pop", bus.unit_found_ack, 4'b0100);
        check("t4 head after pop", bus.res_nonce, 32'hA1);
        step(); bus.unit_found = 4'b0000; settle();
        check("t4 no ack", bus.unit_found_ack, 0);
        exp_nonce = '{32'hA1, 32'hA2, 32'hA3, 32'hC2};
        exp_unit  = '{3'd0, 3'd0, 3'd0, 3'd2};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4 drain%0d valid", i), bus.res_valid, 1);
            check($sformatf("t4 drain%0d nonce", i), bus.res_nonce, exp_nonce[i]);
            check($sformatf("t4 drain%0d unit", i),  bus.res_unit,  exp_unit[i]);
            bus.res_pop = 1;
            step(); settle();
        end
        bus.res_pop = 0;
        check("t4 drained", bus.res_valid, 0);

        // Stop after two chunks, start while busy ignored, then restart
        step(); bus.unit_ready = 4'hF; bus.start = 1;
        bus.nonce_start = 32'h1000; bus.nonce_end = 32'h13FF; bus.chunk_size = 16'h100; settle();
        step(); bus.start = 0; settle();
        chk_load("t5 c0", 4'b1000, 32'h1000, 17'h100);
        step(); bus.unit_ready = 4'b0111; bus.start = 1; bus.nonce_start = 32'h9999; settle();
        chk_load("t5 c1", 4'b0001, 32'h1100, 17'h100);
        step(); bus.start = 0; bus.unit_ready = 4'b0110; bus.stop = 1; settle();
        check("t5 stop load", bus.unit_load, 0);
        check("t5 stop busy", bus.busy, 1);
        step(); bus.stop = 0; settle();
        check("t5 idle", bus.busy, 0);
        check("t5 idle load", bus.unit_load, 0);
        check("t5 no done", bus.done, 0);
        step(); settle();
        check("t5 later load", bus.unit_load, 0);
        check("t5 later done", bus.done, 0);
        step(); bus.start = 1; bus.nonce_start = 32'h2000; bus.nonce_end = 32'h2000; bus.chunk_size = 16'd5; settle();
        step(); bus.start = 0; settle();
        chk_load("t5 restart", 4'b0010, 32'h2000, 17'd1);
        step(); bus.unit_ready = 4'hF; settle();
        check("t5 drain load", bus.unit_load, 0);
        step(); settle();
        check("t5 done", bus.done, 1);

        // Empty range, then chunk_size 0
        step(); bus.start = 1; bus.nonce_start = 32'd10; bus.nonce_end = 32'd5; bus.chunk_size = 16'd4; settle();
        step(); bus.start = 0; settle();
        check("t6 empty load", bus.unit_load, 0);
        check("t6 empty done", bus.done, 1);
        step(); settle();
        check("t6 done end", bus.done, 0);
        check("t6 idle", bus.busy, 0);
        step(); bus.start = 1; bus.nonce_start = 32'd0; bus.nonce_end = 32'd2; bus.chunk_size = 16'd0; settle();
        step(); bus.start = 0; settle();
        chk_load("t6 c0", 4'b0100, 32'd0, 17'd1);
        step(); bus.unit_ready = 4'b1011; settle();
        chk_load("t6 c1", 4'b1000, 32'd1, 17'd1);
        step(); bus.unit_ready = 4'b0011; settle();
        chk_load("t6 c2", 4'b0001, 32'd2, 17'd1);
        step(); bus.unit_ready = 4'b0010; settle();
        check("t6 drain load", bus.unit_load, 0);
        step(); bus.unit_ready = 4'hF; settle();
        check("t6 ready done", bus.done, 0);
        step(); settle();
        check("t6 done", bus.done, 1);

        // start+stop together in IDLE, then reset mid-job flushes everything
        step(); bus.unit_found = 4'b0001; bus.unit_found_nonce = 128'(32'h77);
        bus.start = 1; bus.stop = 1; bus.nonce_start = 32'd0; bus.nonce_end = 32'hFF; bus.chunk_size = 16'd1; settle();
        check("t7 ack", bus.unit_found_ack, 4'b0001);
        step(); bus.unit_found = 0; bus.start = 0; bus.stop = 0; settle();
        check("t7 start wins", bus.busy, 1);
        chk_load("t7 c0", 4'b0010, 32'd0, 17'd1);
        check("t7 fifo nonce", bus.res_nonce, 32'h77);
        rst = 1;
        step(); rst = 0; settle();
        check("t7 rst busy", bus.busy, 0);
        check("t7 rst valid", bus.res_valid, 0);
        check("t7 rst load", bus.unit_load, 0);
        check("t7 rst irq", bus.irq, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
